pill_fill_ctrl: RTL and testbench
=================================

# pill_fill_ctrl

Parametrised pill-bottling sequencer, the next generation of the bottling main controller. It counts single-cycle pill pulses into BCD counters with configurable digit widths and tracks bottles per batch. It runs hopper-starvation and bottle-switch timers sized in seconds from a tick-rate parameter, and reports per-cause error codes and a beeper mode. It sits between the already-edge-detected hopper/conveyor inputs and the seven-segment/beeper display logic.

## Interface
- PILL_DIGITS, 3, BCD digits of pill target/count
- BOTTLE_DIGITS, 2, BCD digits of bottle target/count
- TICKS_PER_SEC, 1000, clk_1khz cycles per second
- SWITCH_SEC, 2, bottle-switch dwell in seconds
- HOPPER_SEC, 3, max seconds between pills before starvation error
- clk_1khz  in  1  sole clock, all logic rising-edge
- clr  in  1  reset, synchronous, active-high
- pill_pulse  in  1  one-cycle pulse per pill dispensed
- conveyor_ok  in  1  level, conveyor running
- start  in  1  one-cycle pulse, leave SETTING
- ack  in  1  one-cycle pulse, leave DONE/FATAL
- emergency_stop  in  1  level, highest functional priority
- target_pills  in  4*PILL_DIGITS  BCD pills per bottle
- target_bottles  in  4*BOTTLE_DIGITS  BCD bottles per batch
- state  out  3  SETTING=0 RUNNING=1 SWITCHING=2 DONE=3 ERROR=4 FATAL=5
- now_pills  out  4*PILL_DIGITS  BCD pills in current bottle
- now_bottles  out  4*BOTTLE_DIGITS  BCD bottles completed
- err_code  out  2  0 none, 1 hopper starved, 2 conveyor stopped
- beep_mode  out  2  0 off, 1 continuous, 2 slow, 3 fast

## Operation
- Reset values: state=SETTING, now_pills=0, now_bottles=0, err_code=0, beep_mode=0, timers and prescaler 0.
- Priority per edge: clr > emergency_stop > state logic.
- emergency_stop high in any state: FATAL. err_code holds its last value.
- SETTING, start:
  - If both targets are nonzero and every digit ≤ 9: latch targets internally, clear both counters, load hopper timer, go to RUNNING.
  - Otherwise start is ignored.
  - Latched targets are immune to input changes until the next start.
- RUNNING, pill_pulse:
  - now_pills increments in BCD with decimal carry and reloads the hopper timer.
  - If the incremented value equals the target, now_bottles increments.
  - If now_bottles then equals its target, go to DONE. Otherwise load the switch timer and go to SWITCHING.
- RUNNING, hopper timer expires with no pulse that cycle: ERROR, err_code=1. A pulse in the expiry cycle wins.
- SWITCHING:
  - pill_pulse is ignored.
  - At switch-timer expiry, if conveyor_ok: clear now_pills, load hopper timer, go to RUNNING.
  - If not conveyor_ok at expiry: ERROR, err_code=2.
- ERROR with err_code=1: pill_pulse → RUNNING. The pill is counted with normal full/bottle checks, and the hopper timer reloads.
- ERROR with err_code=2: conveyor_ok high → RUNNING, now_pills cleared, hopper timer loaded.
- On any exit from ERROR, err_code returns to 0.
- DONE: counters hold. ack → SETTING.
- FATAL: ack while emergency_stop is low → SETTING with counters cleared and err_code=0. ack while emergency_stop is high is ignored.
- beep_mode follows the registered state: DONE=1, ERROR=2, FATAL=3, else 0.
- Counters cannot exceed targets, so BCD wrap occurs only across internal digits (e.g. 009→010, 099→100).

## Timing
- All outputs are registered. The state and counter change caused by an input sampled at edge N are visible after edge N.
- Timers load with SEC×TICKS_PER_SEC. The internal prescaler restarts on every load.
- Expiry is flagged exactly SEC×TICKS_PER_SEC cycles after the load edge. There is no phase dependence on a free-running clock.
- start/ack pulses arriving in a state that does not consume them are dropped. They are not queued.
- clr asserted mid-operation: on the next edge every output returns to its reset value. Latched targets become 0.

## Structure
- Package pill_fill_pkg holds:
  - state encoding constants
  - err_code and beep_mode constants
  - a BCD digit-valid check function
- Sub-module bcd_counter (parameter DIGITS):
  - inputs: clk_1khz, clr, sync clear, inc, compare value
  - outputs: value, equal-after-increment flag
- The controller instantiates bcd_counter twice: once for pills, once for bottles.

## Test plan
- Bench parameters: TICKS_PER_SEC=4, SWITCH_SEC=2, HOPPER_SEC=3.
- Nominal batch:
  - Stimulus: targets 003/02; start; 3 pulses 2 cycles apart.
  - Response: state=2, now_bottles=01. After 8 cycles with conveyor_ok=1: state=1, now_pills=000.
  - Stimulus: 3 more pulses.
  - Response: state=3, now_bottles=02, beep_mode=1. Then ack → state=0.
- BCD carry: target 012/01; 12 pulses → now_pills steps 009→010→011→012, then DONE.
- Hopper starvation:
  - Stimulus: start, then no pulse for 12 cycles.
  - Response: state=4, err_code=1, beep_mode=2.
  - Stimulus: one pulse.
  - Response: state=1, now_pills=001, err_code=0.
- Conveyor fault:
  - Stimulus: conveyor_ok=0 at switch expiry.
  - Response: state=4, err_code=2.
  - Stimulus: raise conveyor_ok.
  - Response: state=1, now_pills=000.
- Emergency:
  - Stimulus: emergency_stop mid-RUNNING.
  - Response: state=5 next edge, beep_mode=3.
  - Stimulus: ack while stop high.
  - Response: ignored.
  - Stimulus: drop stop, then ack.
  - Response: state=0, counters 0.
- Reset/invalid:
  - Stimulus: clr during SWITCHING.
  - Response: all reset values next edge.
  - Stimulus: start with target_pills=000, or with a digit of 0xA.
  - Response: stays SETTING.

Source files
------------

// File: rtl/pill_fill_pkg.sv
// Shared encodings and helpers for the pill bottling sequencer.
// Imported by the controller and its BCD counters.
package pill_fill_pkg;

  typedef enum logic [2:0] {
    S_SETTING   = 3'd0,
    S_RUNNING   = 3'd1,
    S_SWITCHING = 3'd2,
    S_DONE      = 3'd3,
    S_ERROR     = 3'd4,
    S_FATAL     = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_HOPPER   = 2'd1;
  localparam logic [1:0] ERR_CONVEYOR = 2'd2;

  localparam logic [1:0] BEEP_OFF  = 2'd0;
  localparam logic [1:0] BEEP_CONT = 2'd1;
  localparam logic [1:0] BEEP_SLOW = 2'd2;
  localparam logic [1:0] BEEP_FAST = 2'd3;

  function automatic logic bcd_digit_ok(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/pill_fill_ctrl_bcd_counter.sv
// Multi-digit BCD up-counter with sync clear and a flag that
// tells whether the next increment would land on the compare value.
module bcd_counter
  import pill_fill_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                clk_1khz,
  input  logic                clr,
  input  logic                sclr,
  input  logic                inc,
  input  logic [4*DIGITS-1:0] cmp,
  output logic [4*DIGITS-1:0] value,
  output logic                eq_next
);

  logic [4*DIGITS-1:0] nxt;
  logic                carry;

  always_comb begin
    nxt   = value;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (value[4*i +: 4] == 4'd9) begin
          nxt[4*i +: 4] = 4'd0;
        end else begin
          nxt[4*i +: 4] = value[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    eq_next = (nxt == cmp);
  end

  always_ff @(posedge clk_1khz) begin
    if (clr)       value <= '0;
    else if (sclr) value <= '0;
    else if (inc)  value <= nxt;
  end

endmodule

// File: rtl/pill_fill_ctrl.sv
// Pill bottling sequencer: counts pills/bottles in BCD, times the
// hopper and bottle switch, and reports error and beeper modes.
module pill_fill_ctrl
  import pill_fill_pkg::*;
#(
  parameter int PILL_DIGITS   = 3,
  parameter int BOTTLE_DIGITS = 2,
  parameter int TICKS_PER_SEC = 1000,
  parameter int SWITCH_SEC    = 2,
  parameter int HOPPER_SEC    = 3
) (
  input  logic                       clk_1khz,
  input  logic                       clr,
  input  logic                       pill_pulse,
  input  logic                       conveyor_ok,
  input  logic                       start,
  input  logic                       ack,
  input  logic                       emergency_stop,
  input  logic [4*PILL_DIGITS-1:0]   target_pills,
  input  logic [4*BOTTLE_DIGITS-1:0] target_bottles,
  output logic [2:0]                 state,
  output logic [4*PILL_DIGITS-1:0]   now_pills,
  output logic [4*BOTTLE_DIGITS-1:0] now_bottles,
  output logic [1:0]                 err_code,
  output logic [1:0]                 beep_mode
);

  localparam int PW = 4*PILL_DIGITS;
  localparam int BW = 4*BOTTLE_DIGITS;

  state_t          st, st_n;
  logic [1:0]      err_n, beep_n;
  logic [PW-1:0]   tgt_p;
  logic [BW-1:0]   tgt_b;
  logic [15:0]     secs, pre;
  logic            expire, tgt_ok, take;
  logic            ld_hop, ld_sw, latch;
  logic            p_inc, p_clr, p_eq;
  logic            b_inc, b_clr, b_eq;

  always_comb begin
    tgt_ok = (|target_pills) && (|target_bottles);
    for (int i = 0; i < PILL_DIGITS; i++)
      tgt_ok = tgt_ok && bcd_digit_ok(target_pills[4*i +: 4]);
    for (int i = 0; i < BOTTLE_DIGITS; i++)
      tgt_ok = tgt_ok && bcd_digit_ok(target_bottles[4*i +: 4]);
  end

  // One timer serves both dwell phases; they never overlap.
  always_ff @(posedge clk_1khz) begin
    if (clr) begin
      secs <= '0;
      pre  <= '0;
    end else if (ld_hop) begin
      secs <= 16'(HOPPER_SEC);
      pre  <= '0;
    end else if (ld_sw) begin
      secs <= 16'(SWITCH_SEC);
      pre  <= '0;
    end else if (secs != '0) begin
      if (pre == 16'(TICKS_PER_SEC-1)) begin
        pre  <= '0;
        secs <= secs - 16'd1;
      end else begin
        pre <= pre + 16'd1;
      end
    end
  end

  assign expire = (secs == 16'd1) &&
                  (pre == 16'(TICKS_PER_SEC-1));

  always_comb begin
    st_n   = st;
    err_n  = err_code;
    take   = 1'b0;
    latch  = 1'b0;
    ld_hop = 1'b0;
    ld_sw  = 1'b0;
    p_inc  = 1'b0;
    p_clr  = 1'b0;
    b_inc  = 1'b0;
    b_clr  = 1'b0;
    if (emergency_stop) begin
      st_n = S_FATAL;
    end else begin
      unique case (st)
        S_SETTING: if (start && tgt_ok) begin
          latch  = 1'b1;
          p_clr  = 1'b1;
          b_clr  = 1'b1;
          ld_hop = 1'b1;
          st_n   = S_RUNNING;
        end
        S_RUNNING: begin
          if (pill_pulse) take = 1'b1;
          else if (expire) begin
            st_n  = S_ERROR;
            err_n = ERR_HOPPER;
          end
        end
        S_SWITCHING: if (expire) begin
          if (conveyor_ok) begin
            p_clr  = 1'b1;
            ld_hop = 1'b1;
            st_n   = S_RUNNING;
          end else begin
            st_n  = S_ERROR;
            err_n = ERR_CONVEYOR;
          end
        end
        S_ERROR: begin
          if (err_code == ERR_HOPPER && pill_pulse) begin
            take  = 1'b1;
            err_n = ERR_NONE;
            st_n  = S_RUNNING;
          end else if (err_code == ERR_CONVEYOR && conveyor_ok) begin
            err_n  = ERR_NONE;
            p_clr  = 1'b1;
            ld_hop = 1'b1;
            st_n   = S_RUNNING;
          end
        end
        S_DONE: if (ack) st_n = S_SETTING;
        S_FATAL: if (ack) begin
          p_clr = 1'b1;
          b_clr = 1'b1;
          err_n = ERR_NONE;
          st_n  = S_SETTING;
        end
        default: st_n = S_SETTING;
      endcase
    end
    if (take) begin
      p_inc  = 1'b1;
      ld_hop = 1'b1;
      if (p_eq) begin
        b_inc = 1'b1;
        if (b_eq) begin
          st_n = S_DONE;
        end else begin
          ld_hop = 1'b0;
          ld_sw  = 1'b1;
          st_n   = S_SWITCHING;
        end
      end
    end
  end

  always_comb begin
    beep_n = BEEP_OFF;
    unique case (st_n)
      S_DONE:  beep_n = BEEP_CONT;
      S_ERROR: beep_n = BEEP_SLOW;
      S_FATAL: beep_n = BEEP_FAST;
      default: beep_n = BEEP_OFF;
    endcase
  end

  always_ff @(posedge clk_1khz) begin
    if (clr) begin
      st        <= S_SETTING;
      err_code  <= ERR_NONE;
      beep_mode <= BEEP_OFF;
      tgt_p     <= '0;
      tgt_b     <= '0;
    end else begin
      st        <= st_n;
      err_code  <= err_n;
      beep_mode <= beep_n;
      if (latch) begin
        tgt_p <= target_pills;
        tgt_b <= target_bottles;
      end
    end
  end

  assign state = st;

  bcd_counter #(.DIGITS(PILL_DIGITS)) u_pills (
    .clk_1khz (clk_1khz),
    .clr      (clr),
    .sclr     (p_clr),
    .inc      (p_inc),
    .cmp      (tgt_p),
    .value    (now_pills),
    .eq_next  (p_eq)
  );

  bcd_counter #(.DIGITS(BOTTLE_DIGITS)) u_bottles (
    .clk_1khz (clk_1khz),
    .clr      (clr),
    .sclr     (b_clr),
    .inc      (b_inc),
    .cmp      (tgt_b),
    .value    (now_bottles),
    .eq_next  (b_eq)
  );

endmodule

// File: tb/tb_pill_fill_ctrl.sv
// Directed bench for pill_fill_ctrl with a cycle-level reference
// model built from integer counts and absolute deadline cycles.
module tb_pill_fill_ctrl;

  localparam int TPS = 4;
  localparam int SW  = 2;
  localparam int HOP = 3;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        pill_pulse = 1'b0;
  logic        conveyor_ok = 1'b1;
  logic        start = 1'b0;
  logic        ack = 1'b0;
  logic        emergency_stop = 1'b0;
  logic [11:0] target_pills = 12'h000;
  logic [7:0]  target_bottles = 8'h00;
  logic [2:0]  state;
  logic [11:0] now_pills;
  logic [7:0]  now_bottles;
  logic [1:0]  err_code;
  logic [1:0]  beep_mode;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  pill_fill_ctrl #(
    .PILL_DIGITS   (3),
    .BOTTLE_DIGITS (2),
    .TICKS_PER_SEC (TPS),
    .SWITCH_SEC    (SW),
    .HOPPER_SEC    (HOP)
  ) dut (
    .clk_1khz       (clk),
    .clr            (clr),
    .pill_pulse     (pill_pulse),
    .conveyor_ok    (conveyor_ok),
    .start          (start),
    .ack            (ack),
    .emergency_stop (emergency_stop),
    .target_pills   (target_pills),
    .target_bottles (target_bottles),
    .state          (state),
    .now_pills      (now_pills),
    .now_bottles    (now_bottles),
    .err_code       (err_code),
    .beep_mode      (beep_mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] v, input int nd);
    int r = 0;
    for (int i = nd-1; i >= 0; i--) begin
      if (v[4*i +: 4] > 4'd9) return -1;
      r = r*10 + int'(v[4*i +: 4]);
    end
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int x);
    logic [15:0] r = '0;
    int y = x;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(y % 10);
      y = y / 10;
    end
    return r;
  endfunction

  // Reference model: plain counts, targets as integers, timers as
  // absolute edge numbers at which expiry happens.
  int cyc = 0;
  int m_state = 0, m_err = 0, m_p = 0, m_b = 0;
  int m_tp = 0, m_tb = 0, deadline = -1;

  task automatic pill_event();
    m_p++;
    deadline = cyc + HOP*TPS;
    if (m_p == m_tp) begin
      m_b++;
      if (m_b == m_tb) m_state = 3;
      else begin
        m_state = 2;
        deadline = cyc + SW*TPS;
      end
    end
  endtask

  always @(posedge clk) begin
    int tp, tb;
    cyc++;
    tp = bcd2int(16'(target_pills), 3);
    tb = bcd2int(16'(target_bottles), 2);
    if (clr) begin
      m_state = 0; m_err = 0; m_p = 0; m_b = 0;
      m_tp = 0; m_tb = 0; deadline = -1;
    end else if (emergency_stop) begin
      m_state = 5;
    end else begin
      case (m_state)
        0: if (start && tp > 0 && tb > 0) begin
          m_tp = tp; m_tb = tb; m_p = 0; m_b = 0;
          deadline = cyc + HOP*TPS;
          m_state = 1;
        end
        1: if (pill_pulse) pill_event();
           else if (cyc == deadline) begin
             m_state = 4; m_err = 1;
           end
        2: if (cyc == deadline) begin
          if (conveyor_ok) begin
            m_p = 0; deadline = cyc + HOP*TPS; m_state = 1;
          end else begin
            m_state = 4; m_err = 2;
          end
        end
        4: if (m_err == 1 && pill_pulse) begin
             m_err = 0; m_state = 1; pill_event();
           end else if (m_err == 2 && conveyor_ok) begin
             m_err = 0; m_state = 1; m_p = 0;
             deadline = cyc + HOP*TPS;
           end
        3: if (ack) m_state = 0;
        5: if (ack) begin
          m_state = 0; m_p = 0; m_b = 0; m_err = 0;
        end
        default: m_state = 0;
      endcase
    end
  end

  function automatic int beep_of(input int s);
    case (s)
      3: return 1;
      4: return 2;
      5: return 3;
      default: return 0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_state", 32'(state), 32'(m_state));
      chk("model_pills", 32'(now_pills), 32'(int2bcd(m_p)));
      chk("model_bottles", 32'(now_bottles), 32'(int2bcd(m_b)));
      chk("model_err", 32'(err_code), 32'(m_err));
      chk("model_beep", 32'(beep_mode), 32'(beep_of(m_state)));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_pill();
    pill_pulse = 1'b1; step(1); pill_pulse = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1; step(1); ack = 1'b0;
  endtask

  initial begin
    step(2);
    chk_en = 1'b1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pills", 32'(now_pills), 32'h000);
    chk("rst_beep", 32'(beep_mode), 32'd0);
    clr = 1'b0;
    step(1);

    // nominal batch 003/02
    target_pills = 12'h003; target_bottles = 8'h02;
    pulse_start();
    chk("nom_run", 32'(state), 32'd1);
    for (int i = 0; i < 3; i++) begin
      pulse_pill(); if (i < 2) step(1);
    end
    chk("nom_switch", 32'(state), 32'd2);
    chk("nom_b1", 32'(now_bottles), 32'h01);
    step(7);
    chk("nom_dwell", 32'(state), 32'd2);
    step(1);
    chk("nom_back", 32'(state), 32'd1);
    chk("nom_p0", 32'(now_pills), 32'h000);
    for (int i = 0; i < 3; i++) begin
      pulse_pill(); step(1);
    end
    chk("nom_done", 32'(state), 32'd3);
    chk("nom_b2", 32'(now_bottles), 32'h02);
    chk("nom_beep", 32'(beep_mode), 32'd1);
    pulse_ack();
    chk("nom_ack", 32'(state), 32'd0);

    // BCD carry 012/01
    target_pills = 12'h012; target_bottles = 8'h01;
    pulse_start();
    for (int i = 1; i <= 12; i++) begin
      pulse_pill();
      if (i == 9)  chk("bcd_009", 32'(now_pills), 32'h009);
      if (i == 10) chk("bcd_010", 32'(now_pills), 32'h010);
      if (i == 11) chk("bcd_011", 32'(now_pills), 32'h011);
    end
    chk("bcd_012", 32'(now_pills), 32'h012);
    chk("bcd_done", 32'(state), 32'd3);
    pulse_ack();

    // hopper starvation, then conveyor fault
    target_pills = 12'h003; target_bottles = 8'h02;
    pulse_start();
    step(11);
    chk("hop_still", 32'(state), 32'd1);
    step(1);
    chk("hop_err", 32'(state), 32'd4);
    chk("hop_code", 32'(err_code), 32'd1);
    chk("hop_beep", 32'(beep_mode), 32'd2);
    step(2);
    pulse_pill();
    chk("hop_rec", 32'(state), 32'd1);
    chk("hop_p1", 32'(now_pills), 32'h001);
    chk("hop_clr", 32'(err_code), 32'd0);
    pulse_pill(); pulse_pill();
    chk("cv_switch", 32'(state), 32'd2);
    conveyor_ok = 1'b0;
    pulse_pill();
    step(7);
    chk("cv_err", 32'(state), 32'd4);
    chk("cv_code", 32'(err_code), 32'd2);
    step(2);
    conveyor_ok = 1'b1;
    step(1);
    chk("cv_rec", 32'(state), 32'd1);
    chk("cv_p0", 32'(now_pills), 32'h000);

    // emergency stop
    step(2);
    emergency_stop = 1'b1;
    step(1);
    chk("es_fatal", 32'(state), 32'd5);
    chk("es_beep", 32'(beep_mode), 32'd3);
    pulse_ack();
    chk("es_ign", 32'(state), 32'd5);
    emergency_stop = 1'b0;
    step(1);
    pulse_ack();
    chk("es_set", 32'(state), 32'd0);
    chk("es_b0", 32'(now_bottles), 32'h00);

    // clr during SWITCHING
    pulse_start();
    pulse_pill(); pulse_pill(); pulse_pill();
    chk("clr_sw", 32'(state), 32'd2);
    clr = 1'b1;
    step(1);
    chk("clr_state", 32'(state), 32'd0);
    chk("clr_b", 32'(now_bottles), 32'h00);
    chk("clr_p", 32'(now_pills), 32'h000);
    clr = 1'b0;

    // invalid targets
    target_pills = 12'h000;
    pulse_start();
    chk("inv_zero", 32'(state), 32'd0);
    target_pills = 12'h0A1;
    pulse_start();
    chk("inv_digit", 32'(state), 32'd0);
    target_pills = 12'h002; target_bottles = 8'h00;
    pulse_start();
    chk("inv_btl", 32'(state), 32'd0);

    // targets latched at start
    target_pills = 12'h003; target_bottles = 8'h02;
    pulse_start();
    target_pills = 12'h001;
    pulse_pill();
    chk("latch_run", 32'(state), 32'd1);
    chk("latch_p1", 32'(now_pills), 32'h001);
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
